// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types: word/byte aliases, access size, request and
// response bundles, plus an alignment helper used by the responder.
package common;

  typedef logic [63:0] u64;
  typedef logic [7:0]  u8;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2,
    MSIZE8 = 2'd3
  } msize_t;

  typedef struct packed {
    logic    valid;
    u64      addr;
    msize_t  size;
    strobe_t strobe;
    u64      data;
  } dbus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u64   data;
  } dbus_resp_t;

  function automatic logic misaligned(input logic [2:0] a,
                                      input msize_t sz);
    logic m;
    m = 1'b0;
    unique case (sz)
      MSIZE1: m = 1'b0;
      MSIZE2: m = a[0];
      MSIZE4: m = |a[1:0];
      MSIZE8: m = |a[2:0];
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus handshake bundle: dreq from the memory stage, dresp back.
// master drives dreq; slave drives dresp.
interface dbus_if;
  import common::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_sram_responder_mem.sv
// 8-lane byte-writable 64-bit array, no reset on contents.
// Ports: clk, en_i (accept), idx_i, we_i (lane enables), wdata_i, rdata_o.
module dbus_resp_mem
  import common::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = 12
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [7:0]       we_i,
  input  u64               wdata_i,
  output u64               rdata_o
);

  u64 mem_q [DEPTH_WORDS];
  u64 rdata_q;
  u64 merged;

  // Write-first: the read port sees this edge's write.
  always_comb begin
    merged = mem_q[idx_i];
    for (int i = 0; i < 8; i++) begin
      if (we_i[i]) merged[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 8; i++) begin
        if (we_i[i])
          mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      rdata_q <= merged;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: one request at a time, fixed LATENCY to data_ok.
// Ports: clk, rst (async active-low), bus (dbus_if.slave), err (sticky).
// Optional DBUS_RESP_MISALIGN_CHECK_EN: flag/suppress misaligned accesses.
module dbus_sram_responder
  import common::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2,
  parameter u64 BASE_ADDR   = 64'h8000_0000
) (
  input  logic clk,
  input  logic rst,
  dbus_if.slave bus,
  output logic err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;

  logic             accept;
  logic             mis;
  u64               off;
  logic [IDX_W-1:0] idx;
  logic [7:0]       we;
  u64               rdata;
  dbus_resp_t       resp;

  assign off    = bus.dreq.addr - BASE_ADDR;
  assign idx    = off[IDX_W+2:3];
  assign accept = (state_q == S_IDLE) && bus.dreq.valid;

`ifdef DBUS_RESP_MISALIGN_CHECK_EN
  assign mis = misaligned(bus.dreq.addr[2:0], bus.dreq.size);
  logic unused_off;
  assign unused_off = ^{off[63:IDX_W+3], off[2:0]};
`else
  assign mis = 1'b0;
  logic unused_off;
  assign unused_off = ^{off[63:IDX_W+3], off[2:0], bus.dreq.size};
`endif

  assign we = (accept && !mis) ? bus.dreq.strobe : 8'h00;

  dbus_resp_mem #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk     (clk),
    .en_i    (accept),
    .idx_i   (idx),
    .we_i    (we),
    .wdata_i (bus.dreq.data),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    zero_d       = zero_q;
    err_d        = err_q;
    resp.addr_ok = 1'b0;
    resp.data_ok = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        resp.addr_ok = bus.dreq.valid;
        if (bus.dreq.valid) begin
          zero_d = mis;
          err_d  = err_q | mis;
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 16'(LATENCY - 2);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 16'd0) state_d = S_RESP;
        else                cnt_d   = cnt_q - 16'd1;
      end
      S_RESP: begin
        resp.data_ok = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // zero_q masks the array read port: 0 after reset and on misaligned access.
  assign resp.data = zero_q ? 64'h0 : rdata;
  assign bus.dresp = resp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      zero_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

`ifdef DBUS_RESP_MISALIGN_CHECK_EN
  assign err = err_q;
`else
  assign err = 1'b0;
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench for dbus_sram_responder (DEPTH_WORDS=16, LATENCY=2).
// Works with or without DBUS_RESP_MISALIGN_CHECK_EN defined.
module tb_dbus_sram_responder;
  import common::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err;
  int   n_run = 0;
  int   n_fail = 0;

  dbus_if bus();

  dbus_sram_responder #(
    .DEPTH_WORDS (16),
    .LATENCY     (LAT),
    .BASE_ADDR   (64'h8000_0000)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave),
    .err (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input u64 got, input u64 exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input u64 a, input msize_t sz,
                       input strobe_t st, input u64 d);
    bus.dreq.valid  = v;
    bus.dreq.addr   = a;
    bus.dreq.size   = sz;
    bus.dreq.strobe = st;
    bus.dreq.data   = d;
  endtask

  task automatic txn(input string tag, input u64 a, input msize_t sz,
                     input strobe_t st, input u64 d, output u64 rd);
    drive(1'b1, a, sz, st, d);
    #1;
    chk({tag, ".aok"}, 64'(bus.dresp.addr_ok), 64'd1);
    step();
    for (int i = 1; i < LAT; i++) begin
      chk({tag, ".wait_dok"}, 64'(bus.dresp.data_ok), 64'd0);
      chk({tag, ".wait_aok"}, 64'(bus.dresp.addr_ok), 64'd0);
      step();
    end
    chk({tag, ".dok"}, 64'(bus.dresp.data_ok), 64'd1);
    rd = bus.dresp.data;
    bus.dreq.valid = 1'b0;
    step();
    chk({tag, ".dok_clr"}, 64'(bus.dresp.data_ok), 64'd0);
  endtask

  u64 rd;
  u64 wx;

  initial begin
    drive(1'b0, 64'h0, MSIZE8, 8'h00, 64'h0);
    #12;
    chk("rst.dok", 64'(bus.dresp.data_ok), 64'd0);
    chk("rst.data", bus.dresp.data, 64'h0);
    chk("rst.err", 64'(err), 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle.aok", 64'(bus.dresp.addr_ok), 64'd0);

    txn("wr_full", 64'h8000_0010, MSIZE8, 8'hFF,
        64'h0123_4567_89AB_CDEF, rd);
    chk("wr_full.data", rd, 64'h0123_4567_89AB_CDEF);
    txn("rd_full", 64'h8000_0010, MSIZE8, 8'h00, 64'h0, rd);
    chk("rd_full.data", rd, 64'h0123_4567_89AB_CDEF);

    txn("wr_part", 64'h8000_0010, MSIZE4, 8'h0F,
        64'hFFFF_FFFF_AAAA_BBBB, rd);
    txn("rd_part", 64'h8000_0010, MSIZE8, 8'h00, 64'h0, rd);
    chk("rd_part.data", rd, 64'h0123_4567_AAAA_BBBB);

    wx = 64'h1122_3344_5566_7788;
    txn("wr_wrap", 64'h8000_0080, MSIZE8, 8'hFF, wx, rd);
    txn("rd_wrap", 64'h8000_0000, MSIZE8, 8'h00, 64'h0, rd);
    chk("rd_wrap.data", rd, wx);

    drive(1'b1, 64'h8000_0000, MSIZE8, 8'h00, 64'h0);
    step();
    chk("rstw.in_wait_dok", 64'(bus.dresp.data_ok), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rstw.data", bus.dresp.data, 64'h0);
    step();
    chk("rstw.dok", 64'(bus.dresp.data_ok), 64'd0);
    bus.dreq.valid = 1'b0;
    step();
    chk("rstw.dok2", 64'(bus.dresp.data_ok), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rstw.idle_aok", 64'(bus.dresp.addr_ok), 64'd0);
    txn("rd_post_rst", 64'h8000_0010, MSIZE8, 8'h00, 64'h0, rd);
    chk("rd_post_rst.data", rd, 64'h0123_4567_AAAA_BBBB);

    drive(1'b1, 64'h8000_0000, MSIZE8, 8'h00, 64'h0);
    #1;
    chk("drop.aok", 64'(bus.dresp.addr_ok), 64'd1);
    step();
    bus.dreq.valid = 1'b0;
    #1;
    chk("drop.wait_dok", 64'(bus.dresp.data_ok), 64'd0);
    step();
    chk("drop.dok", 64'(bus.dresp.data_ok), 64'd1);
    chk("drop.data", bus.dresp.data, wx);
    bus.dreq.valid = 1'b1;
    #1;
    chk("drop.resp_aok", 64'(bus.dresp.addr_ok), 64'd0);
    step();
    chk("drop.next_aok", 64'(bus.dresp.addr_ok), 64'd1);
    chk("drop.hold_data", bus.dresp.data, wx);
    bus.dreq.valid = 1'b0;
    step();
    chk("drop.idle_dok", 64'(bus.dresp.data_ok), 64'd0);

    txn("wr_mis", 64'h8000_0002, MSIZE4, 8'h3C,
        64'h0000_DEAD_BEEF_0000, rd);
`ifdef DBUS_RESP_MISALIGN_CHECK_EN
    chk("wr_mis.data", rd, 64'h0);
    chk("wr_mis.err", 64'(err), 64'd1);
    txn("rd_mis", 64'h8000_0000, MSIZE8, 8'h00, 64'h0, rd);
    chk("rd_mis.data", rd, wx);
    chk("rd_mis.err_sticky", 64'(err), 64'd1);
`else
    chk("wr_mis.data", rd, 64'h1122_DEAD_BEEF_7788);
    chk("wr_mis.err", 64'(err), 64'd0);
    txn("rd_mis", 64'h8000_0000, MSIZE8, 8'h00, 64'h0, rd);
    chk("rd_mis.data", rd, 64'h1122_DEAD_BEEF_7788);
    chk("rd_mis.err_sticky", 64'(err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Data-bus responder: the target side of the `dbus_req_t`/`dbus_resp_t` handshake driven by the pipeline's memory stage. It accepts one request at a time, applies byte-strobed writes or reads a 64-bit word from an internal SRAM-style array, and returns `data_ok` after a fixed, configurable latency. It is used as the data memory in simulation top-levels and as the backing store for memory-stage verification.

## Interface
Parameters:
- `DEPTH_WORDS`, 4096: number of 64-bit words; power of two, ≥2.
- `LATENCY`, 2: cycles from accept to `data_ok`; ≥1.
- `BASE_ADDR`, 64'h8000_0000: byte address mapped to word 0.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `dreq`  in  `dbus_req_t`: `valid`, `addr[63:0]`, `size` (`msize_t`: 1/2/4/8 B), `strobe[7:0]`, `data[63:0]`.
- `dresp`  out  `dbus_resp_t`: `addr_ok`, `data_ok`, `data[63:0]`.
- `err`  out  1: sticky misalignment flag (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `addr_ok = dreq.valid` (combinational). Accept happens on a rising edge where `valid=1` in IDLE. At accept:
  - word index = `((addr - BASE_ADDR) >> 3) & (DEPTH_WORDS-1)`; out-of-range addresses wrap by truncation, with no error.
  - `strobe != 0`: write lanes i where `strobe[i]=1` with `data[8i+7:8i]`. Other lanes are unchanged.
  - `strobe == 0`: read. Latch the full 64-bit word into the response register. The initiator extracts lanes; no shifting is done here.
  - Writes also latch the post-write word; it is returned but ignored by the initiator.
  - `LATENCY==1` → RESP; otherwise → WAIT with counter = `LATENCY-2`.
- WAIT: decrement the counter. At 0 → RESP. `addr_ok=0`.
- RESP: `data_ok=1` for exactly one cycle, `dresp.data` = latched word → IDLE.
- `addr_ok` is 0 in WAIT and RESP. `data_ok` is 0 outside RESP.
- The initiator holds `dreq` stable until `data_ok`. If `valid` drops after accept, the transaction still completes, including `data_ok`. The write has already been committed.
- Back-to-back: the next accept is no earlier than the cycle after RESP.
- `dresp.data` holds its last value outside RESP.

## Timing
- Accept in cycle T → `data_ok` in cycle T+LATENCY → next `addr_ok` possible in T+LATENCY+1.
- Throughput: 1 request per LATENCY+1 cycles.
- Reset (`rst=0`, at any time, including mid-WAIT or RESP):
  - immediately: state=IDLE, counter=0, `data_ok=0`, `dresp.data=0`, `err=0`.
  - `addr_ok` follows `valid` once `rst=1`.
- Array contents are not reset. A write committed before reset persists.
- Read-after-write to the same word in consecutive transactions returns the new data.

## Configuration
- `DBUS_RESP_MISALIGN_CHECK_EN` defined: at accept, if `addr` is not aligned to `size` (mod 2/4/8), the access is misaligned:
  - no array write;
  - the latched word is 64'h0;
  - `err` is set and stays 1 until reset;
  - the handshake timing is unchanged.
- Not defined: no alignment check. `err` is tied to 0, and accesses proceed with the word-index rule.

## Structure
- Shared package `common`: `u64`, `u8`, `msize_t`, `strobe_t`, `dbus_req_t`, `dbus_resp_t`.
- Local FSM state enum stays in this module.
- One sub-module, `dbus_resp_mem`: an 8-lane byte-writable array with `clk`, index, lane write-enables, wdata and rdata. Read is synchronous with write-first behaviour within the accept edge.

## Test plan
- LATENCY=2: write addr 0x8000_0010, strobe 8'hFF, data 64'h0123_4567_89AB_CDEF → `addr_ok` in T, `data_ok` in T+2. Read of the same address → `data` 64'h0123_4567_89AB_CDEF.
- Partial write, strobe 8'h0F, data 64'hFFFF_FFFF_AAAA_BBBB, to that word, then read → 64'h0123_4567_AAAA_BBBB.
- Wrap: with DEPTH_WORDS=16, write 0x8000_0080 (index 16→0), then read 0x8000_0000 → same data.
- Reset asserted during WAIT → `data_ok` never rises, state IDLE. After release, a fresh read succeeds with LATENCY timing.
- `valid` dropped in WAIT → `data_ok` still pulses at T+LATENCY, and the next `addr_ok` is not asserted before T+LATENCY+1.
- With macro: 4-byte write at 0x8000_0002 → `err`=1, `data_ok` data 0, and the word is unchanged on readback. Without macro: `err` stays 0.
